// File: rtl/mt9d111_sim_pkg.sv
// mt9d111_sim_pkg: default timing constants, derived totals and byte-select helper for the MT9D111 camera model
package mt9d111_sim_pkg;
  localparam int H_ACTIVE_DEF    = 800;
  localparam int V_ACTIVE_DEF    = 600;
  localparam int H_BLANK_DEF     = 200;
  localparam int VSYNC_LINES_DEF = 2;
  localparam int V_BACK_DEF      = 4;
  localparam int V_FRONT_DEF     = 4;
  typedef enum logic {BYTE_HI = 1'b0, BYTE_LO = 1'b1} byte_sel_e;
  function automatic int h_total(int h_active, int h_blank);
    return 2 * h_active + h_blank;
  endfunction
  function automatic int v_total(int vsync_lines, int v_back, int v_active, int v_front);
    return vsync_lines + v_back + v_active + v_front;
  endfunction
  function automatic int clog2_min1(int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction
  function automatic logic [7:0] byte_sel(logic [15:0] pix, byte_sel_e sel);
    return (sel == BYTE_LO) ? pix[7:0] : pix[15:8];
  endfunction
endpackage

// File: rtl/mt9d111_sim_timing.sv
// mt9d111_sim_timing: phase/h_cnt/v_cnt slot counters; ports clk, rst in; pclk, slot_adv, vsync, href, byte_lo, row, col out
module mt9d111_sim_timing
  import mt9d111_sim_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int H_BLANK     = H_BLANK_DEF,
  parameter int VSYNC_LINES = VSYNC_LINES_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  localparam int RW = clog2_min1(V_ACTIVE),
  localparam int CW = clog2_min1(H_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pclk,
  output logic          slot_adv,
  output logic          vsync,
  output logic          href,
  output byte_sel_e     byte_lo,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_BLANK);
  localparam int V_TOTAL = v_total(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
  localparam int HW      = clog2_min1(H_TOTAL);
  localparam int VW      = clog2_min1(V_TOTAL);
  localparam int V_START = VSYNC_LINES + V_BACK;
  logic          phase;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          active;
  int            row_i;
  assign pclk     = phase;
  assign slot_adv = phase;
  assign h_last   = h_cnt == HW'(H_TOTAL - 1);
  assign v_last   = v_cnt == VW'(V_TOTAL - 1);
  // counters advance on the edge where pclk falls, i.e. while phase is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  end
  always_comb begin
    row_i   = int'(v_cnt) - V_START;
    active  = (row_i >= 0) && (row_i < V_ACTIVE);
    vsync   = int'(v_cnt) < VSYNC_LINES;
    href    = active && (int'(h_cnt) < 2 * H_ACTIVE);
    row     = active ? RW'(row_i) : '0;
    col     = href ? CW'(h_cnt >> 1) : '0;
    byte_lo = byte_sel_e'(h_cnt[0]);
  end
endmodule

// File: rtl/mt9d111_sim.sv
// mt9d111_sim: MT9D111 DVP camera model replaying an RGB565 frame store; ports CLOCK65, RESET in; MT9D111_PCLK/VSYNC/HREF/D out; macro MT9D111_SIM_PATTERN_EN selects a row/col test pattern
module mt9d111_sim
  import mt9d111_sim_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int H_BLANK     = H_BLANK_DEF,
  parameter int VSYNC_LINES = VSYNC_LINES_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int V_FRONT     = V_FRONT_DEF
) (
  input  logic       CLOCK65,
  input  logic       RESET,
  output logic       MT9D111_PCLK,
  output logic       MT9D111_VSYNC,
  output logic       MT9D111_HREF,
  output logic [7:0] MT9D111_D
);
  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam int RW   = clog2_min1(V_ACTIVE);
  localparam int CW   = clog2_min1(H_ACTIVE);
  localparam int AW   = clog2_min1(NPIX);
  // loaded hierarchically by the bench, row-major
  logic [15:0] pixel_rgb565 [0:NPIX-1];
  logic          pclk;
  logic          slot_adv;
  logic          vsync;
  logic          href;
  byte_sel_e     byte_lo;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [15:0]   pix;
  mt9d111_sim_timing #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) u_timing (
    .clk(CLOCK65), .rst(RESET), .pclk(pclk), .slot_adv(slot_adv), .vsync(vsync),
    .href(href), .byte_lo(byte_lo), .row(row), .col(col)
  );
`ifdef MT9D111_SIM_PATTERN_EN
  assign pix = {8'(row), 8'(col)};
`else
  // index is forced to 0 outside active bytes so the store is never addressed out of range
  int idx;
  always_comb begin
    idx = href ? int'(row) * H_ACTIVE + int'(col) : 0;
    pix = pixel_rgb565[AW'(idx)];
  end
`endif
  assign MT9D111_PCLK = pclk;
  always_ff @(posedge CLOCK65) begin
    if (RESET) begin
      MT9D111_VSYNC <= 1'b0;
      MT9D111_HREF  <= 1'b0;
      MT9D111_D     <= 8'h00;
    end else if (slot_adv) begin
      MT9D111_VSYNC <= vsync;
      MT9D111_HREF  <= href;
      MT9D111_D     <= href ? byte_sel(pix, byte_lo) : 8'h00;
    end
  end
endmodule

// File: tb/tb_mt9d111_sim.sv
// tb_mt9d111_sim: scoreboard bench for mt9d111_sim with a slot-arithmetic reference model
module tb_mt9d111_sim;
  localparam int HA = 4, VA = 2, HB = 2, VS = 1, VB = 1, VF = 1;
  localparam int HT = 2 * HA + HB, VT = VS + VB + VA + VF, NPIX = HA * VA;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pclk, vsync, href;
  logic [7:0] d;
  logic [15:0] ref_mem [0:NPIX-1];
  logic [9:0] sb [$];
  logic [9:0] e;
  int checks = 0, failures = 0;
  logic rst_seen = 1'b1, prev_pclk = 1'b0, vs_prev = 1'b0, hr_prev = 1'b0, vs_seen = 1'b0;
  int vs_gap = 0, hr_len = 0, hr_pulses = 0;

  mt9d111_sim #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .CLOCK65(clk), .RESET(rst), .MT9D111_PCLK(pclk), .MT9D111_VSYNC(vsync),
    .MT9D111_HREF(href), .MT9D111_D(d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected {vsync, href, d} of output slot s counted from frame start
  function automatic logic [9:0] model(input int s);
    int h, v, row;
    logic hr;
    logic [15:0] p;
    logic [7:0] dd;
    h = s % HT;
    v = (s / HT) % VT;
    row = v - VS - VB;
    hr = (row >= 0) && (row < VA) && (h < 2 * HA);
`ifdef MT9D111_SIM_PATTERN_EN
    p = {8'(row), 8'(h / 2)};
`else
    p = hr ? ref_mem[row * HA + h / 2] : 16'h0000;
`endif
    dd = !hr ? 8'h00 : ((h % 2 == 0) ? p[15:8] : p[7:0]);
    return {v < VS, hr, dd};
  endfunction

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_out", 32'({pclk, vsync, href, d}), 32'd0);
      vs_prev = 1'b0; hr_prev = 1'b0; vs_seen = 1'b0;
      vs_gap = 0; hr_len = 0; hr_pulses = 0;
    end else begin
      chk("pclk_toggle", 32'(pclk), 32'(!prev_pclk));
      if (pclk) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rise got=%b%b%02h want=none at %0t", vsync, href, d, $time);
        end else begin
          e = sb.pop_front();
          chk("stream", 32'({vsync, href, d}), 32'(e));
        end
        if (href && !hr_prev) hr_pulses++;
        if (href) hr_len++;
        else begin
          if (hr_prev) chk("href_len", 32'(hr_len), 32'(2 * HA));
          hr_len = 0;
        end
        if (vsync && !vs_prev) begin
          if (vs_seen) begin
            chk("vsync_period", 32'(vs_gap), 32'(HT * VT));
            chk("href_pulses", 32'(hr_pulses), 32'(VA));
          end
          vs_seen = 1'b1; vs_gap = 0; hr_pulses = 0;
        end
        vs_gap++;
        vs_prev = vsync;
        hr_prev = href;
      end
    end
    prev_pclk = pclk;
  end

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // release reset, expect the first rise to still show reset values, then n slots
  task automatic run(input int n);
    sb.push_back(10'h000);
    for (int s = 0; s < n; s++) sb.push_back(model(s));
    @(negedge clk);
    rst = 1'b0;
    drain();
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic load(input logic rnd);
    for (int i = 0; i < NPIX; i++) begin
      ref_mem[i] = rnd ? 16'($urandom) : 16'hA000 + 16'(i);
      dut.pixel_rgb565[i] = ref_mem[i];
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    load(1'b0);
    run(2 * HT * VT + 1);
    load(1'b1);
    run(3 * HT + 4);
    run(HT * VT + 10);
    for (int k = 0; k < 4; k++) begin
      load(1'b1);
      run(int'($urandom_range(5, 120)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end
endmodule
